cnt_ctrl: RTL and testbench
===========================

# cnt_ctrl

Command-driven sequencer for the 4-bit up/down `counter` (ports `clk, rst, ce, up, data`). It accepts step commands over a valid/ready handshake and can optionally clear the counter first. It then drives the counter's `ce`/`up` for exactly the requested number of cycles and returns the final count, plus wrap and abort flags, over a second valid/ready handshake. It sits between a test or control agent and a single `counter` instance, and is the only driver of that counter's control inputs.

## Interface
- `WIDTH`, 4: counter data width; also the width of `cmd_len`.
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high with `cmd_valid` at a posedge.
- `cmd_up` in 1: direction; 1 = increment, 0 = decrement.
- `cmd_len` in WIDTH: number of counter steps, 0..2^WIDTH-1.
- `cmd_clr` in 1: clear the counter to 0 before stepping.
- `cmd_abort` in 1: level; stops an active run early.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high with `rsp_valid` at a posedge.
- `rsp_data` out WIDTH: counter value at completion.
- `rsp_wrap` out 1: the counter wrapped (F→0 or 0→F) during the run.
- `rsp_abort` out 1: the run ended because of `cmd_abort`.
- `cnt_rst` out 1: to the counter's `rst`.
- `cnt_ce` out 1: to the counter's `ce`.
- `cnt_up` out 1: to the counter's `up`.
- `cnt_data` in WIDTH: from the counter's `data`.

## Operation
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On accept: latch `cmd_up` into `cnt_up`, `cmd_len` into `remaining`, and clear the wrap and abort flags.
  - Next state is CLR if `cmd_clr`=1; otherwise RUN if `cmd_len`≠0, else DONE.
- CLR:
  - Exactly one cycle with `cnt_rst`=1 and `cnt_ce`=0. The counter loads 0.
  - Next state is RUN if `remaining`≠0, else DONE.
- RUN:
  - `cnt_ce`=1 in every RUN cycle; `remaining` decrements at each edge.
  - Leave for DONE at the edge where `remaining`==1.
  - Exactly `cmd_len` counter steps occur.
- Wrap detection (RUN cycles only):
  - Set the wrap flag if `cnt_up`=1 and `cnt_data`==all-ones.
  - Set the wrap flag if `cnt_up`=0 and `cnt_data`==0.
- Abort:
  - `cmd_abort` sampled high in RUN with `remaining`>1: go to DONE and set the abort flag. The step in that cycle still counts.
  - If abort coincides with `remaining`==1, completion wins and `rsp_abort`=0.
  - Abort is ignored in IDLE, CLR and DONE.
- DONE:
  - `rsp_valid`=1 and `cnt_ce`=0.
  - `rsp_data` = `cnt_data`, which is stable because `ce` is low.
  - `rsp_wrap` and `rsp_abort` show their flags.
  - Hold until `rsp_ready`, then go to IDLE.
  - Outside DONE, `rsp_data`, `rsp_wrap` and `rsp_abort` read 0.
- `cnt_up` holds its last value outside RUN.
- `cnt_rst` = `rst` OR (state==CLR).

## Timing
- All state and all control outputs are registered, except two combinational terms:
  - `cnt_rst` (OR with `rst`);
  - `rsp_data` (passthrough of `cnt_data` gated by DONE).
- Reset values (after a posedge with `rst`=1):
  - state IDLE, `cmd_ready`=1, `cnt_ce`=0, `cnt_up`=0;
  - `rsp_valid`=0, `rsp_wrap`=0, `rsp_abort`=0, `remaining`=0;
  - `cnt_rst`=1 while `rst` is high.
- Latency from a command accepted at edge T, length L>0, no clear:
  - `cnt_ce` is high in cycles T+1..T+L;
  - `rsp_valid` rises in cycle T+L+1.
  - With clear, add one cycle: CLR occupies cycle T+1.
- L=0 without clear: `rsp_valid` in cycle T+1.
- Minimum command-to-command spacing is L+2 cycles: RUN, DONE, then IDLE for one cycle. There is no back-to-back acceptance.
- `rst` asserted in any state takes effect at the next edge: the run is dropped, no response is produced, and the counter is also reset via `cnt_rst`.
- `cmd_valid` outside IDLE is ignored; the command is not buffered.

## Structure
- Package `cnt_ctrl_pkg` holds:
  - `state_t` enum {IDLE, CLR, RUN, DONE};
  - `CNT_WIDTH` = 4, used as the `WIDTH` default.
- Single module; no sub-module is needed.
- The bench instantiates `cnt_ctrl` and `counter` together.

## Test plan
- Reset, then cmd up / L=3 / clr=1:
  - `cnt_rst` high 1 cycle, then `cnt_ce` high 3 cycles;
  - `rsp_data`=3, `rsp_wrap`=0, `rsp_abort`=0.
- cmd down / L=2 / clr=1:
  - `rsp_data`='he, `rsp_wrap`=1 (0→F wrap).
- cmd L=0 / clr=0 with counter at 5:
  - `cnt_ce` never high; `rsp_valid` on the cycle after accept; `rsp_data`=5.
- Counter at 3, cmd up / L=10, `cmd_abort` high in the 4th RUN cycle:
  - 4 steps taken; `rsp_data`=7, `rsp_abort`=1.
- Hold `rsp_ready` low for 5 cycles in DONE while driving a new `cmd_valid`:
  - `rsp_valid` and `rsp_data` stable; `cmd_ready`=0; the new command is not accepted until after the response handshake.
- Assert `rst` in the 2nd RUN cycle of an L=8 run:
  - next cycle: state IDLE, `cnt_ce`=0, `rsp_valid`=0, `cmd_ready`=1;
  - counter reads 0 after `rst` is released.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: shared types and constants for the counter sequencer.
//   state_t   : sequencer state encoding (also visible on the debug port)
//   CNT_WIDTH : default counter / command-length width
package cnt_ctrl_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter.sv
// counter: WIDTH-bit up/down counter with synchronous active-high reset.
//   clk  : clock
//   rst  : synchronous reset, loads 0
//   ce   : count enable; one step per enabled edge
//   up   : 1 = increment, 0 = decrement (wraps modulo 2^WIDTH)
//   data : current count
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             up,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (ce) begin
      if (up) data <= data + 1'b1;
      else    data <= data - 1'b1;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: command-driven sequencer for a single up/down counter.
//   A command (direction, length, optional clear) is accepted, the counter's
//   ce/up are driven for exactly cmd_len cycles (or fewer on abort), and the
//   final count plus wrap/abort flags are returned as a response.
//
// Handshakes (both sides): a transfer happens at a posedge where valid and
// ready are both high. cmd_ready is only high in IDLE and commands are not
// buffered; rsp_valid is held with stable data until rsp_ready is seen.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake
//   cmd_up, cmd_len, cmd_clr     : command payload
//   cmd_abort                    : level, stops an active run early
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data, rsp_wrap, rsp_abort: response payload (0 outside DONE)
//   cnt_rst, cnt_ce, cnt_up      : drive the counter
//   cnt_data                     : counter value
//   dbg_state                    : current FSM state
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_up,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic             cmd_clr,
  input  logic             cmd_abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_wrap,
  output logic             rsp_abort,
  output logic             cnt_rst,
  output logic             cnt_ce,
  output logic             cnt_up,
  input  logic [WIDTH-1:0] cnt_data,
  output logic [1:0]       dbg_state
);

  localparam logic [WIDTH-1:0] LEN_ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic             wrap_flag;
  logic             wrap_hit;
  logic             last_step;

  // The counter steps at the end of each RUN cycle, so a wrap happens on
  // this edge when the value about to be stepped sits at the boundary.
  assign wrap_hit  = cnt_up ? (cnt_data == '1) : (cnt_data == '0);
  assign last_step = (remaining == LEN_ONE);

  assign cnt_rst   = rst | (state == CLR);
  // ce is low in DONE, so cnt_data is stable for the whole response.
  assign rsp_data  = (state == DONE) ? cnt_data : '0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      cnt_ce    <= 1'b0;
      cnt_up    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wrap  <= 1'b0;
      rsp_abort <= 1'b0;
      remaining <= '0;
      wrap_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cnt_up    <= cmd_up;
            remaining <= cmd_len;
            wrap_flag <= 1'b0;
            rsp_wrap  <= 1'b0;
            rsp_abort <= 1'b0;
            cmd_ready <= 1'b0;
            if (cmd_clr) begin
              state <= CLR;
            end else if (cmd_len != '0) begin
              state  <= RUN;
              cnt_ce <= 1'b1;
            end else begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end
          end
        end

        CLR: begin
          if (remaining != '0) begin
            state  <= RUN;
            cnt_ce <= 1'b1;
          end else begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end

        RUN: begin
          remaining <= remaining - 1'b1;
          if (wrap_hit) wrap_flag <= 1'b1;
          // Completion beats a coincident abort; either way the step taken
          // in this cycle counts.
          if (last_step || cmd_abort) begin
            state     <= DONE;
            cnt_ce    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_wrap  <= wrap_flag | wrap_hit;
            rsp_abort <= ~last_step;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_wrap  <= 1'b0;
            rsp_abort <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          cnt_ce    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed bench for cnt_ctrl driving a real counter.
module tb_cnt_ctrl;
  import cnt_ctrl_pkg::*;

  localparam int W = CNT_WIDTH;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_up;
  logic [W-1:0] cmd_len;
  logic         cmd_clr;
  logic         cmd_abort;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_wrap;
  logic         rsp_abort;
  logic         cnt_rst;
  logic         cnt_ce;
  logic         cnt_up;
  logic [W-1:0] cnt_data;
  logic [1:0]   dbg_state;

  cnt_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_up(cmd_up), .cmd_len(cmd_len), .cmd_clr(cmd_clr),
    .cmd_abort(cmd_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_wrap(rsp_wrap), .rsp_abort(rsp_abort),
    .cnt_rst(cnt_rst), .cnt_ce(cnt_ce), .cnt_up(cnt_up),
    .cnt_data(cnt_data), .dbg_state(dbg_state)
  );

  counter #(.WIDTH(W)) u_cnt (
    .clk(clk), .rst(cnt_rst), .ce(cnt_ce), .up(cnt_up), .data(cnt_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Free-running activity counters, sampled mid-cycle.
  int ce_total  = 0;
  int rst_total = 0;
  always @(negedge clk) begin
    if (cnt_ce)  ce_total  = ce_total + 1;
    if (cnt_rst) rst_total = rst_total + 1;
  end

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];   // {abort, wrap, data}
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: got %0h expected no response",
                   {rsp_abort, rsp_wrap, rsp_data});
        end else begin
          e = exp_q.pop_front();
          check("rsp", {26'd0, rsp_abort, rsp_wrap, rsp_data}, {26'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int t_acc;
  int ce0;
  int rst0;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic up, input logic [W-1:0] len,
                      input logic clr);
    int n;
    n = 0;
    cmd_up    = up;
    cmd_len   = len;
    cmd_clr   = clr;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) timeout("cmd_accept");
    ce0  = ce_total;
    rst0 = rst_total;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  // Waits for rsp_valid, reports cycles since accept, then for the handshake.
  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout("rsp_valid");
    lat = cyc - t_acc;
    while (rsp_valid && n < 120) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid) timeout("rsp_handshake");
  endtask

  task automatic run_cmd(input string name, input logic up,
                         input logic [W-1:0] len, input logic clr,
                         input logic [5:0] exp_rsp, input int exp_lat,
                         input int exp_ce, input int exp_rst);
    int lat;
    exp_q.push_back(exp_rsp);
    send(up, len, clr);
    wait_rsp(lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_ce"}, ce_total - ce0, exp_ce);
    check({name, "_rst"}, rst_total - rst0, exp_rst);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_up    = 1'b0;
    cmd_len   = '0;
    cmd_clr   = 1'b0;
    cmd_abort = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", dbg_state, IDLE);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cnt_ce", cnt_ce, 0);
    check("rst_cnt_up", cnt_up, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_flags", {rsp_abort, rsp_wrap}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_cnt_rst", cnt_rst, 1);
    check("rst_cnt_data", cnt_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_cnt_rst", cnt_rst, 0);

    // up 3 with clear: CLR then 3 RUN cycles, response after 4 cycles
    run_cmd("up3_clr", 1'b1, 4'd3, 1'b1, {1'b0, 1'b0, 4'h3}, 4, 3, 1);
    // down 2 with clear: 0 -> F -> E, wraps
    run_cmd("dn2_clr", 1'b0, 4'd2, 1'b1, {1'b0, 1'b1, 4'hE}, 3, 2, 1);
    // up 5 with clear: counter to 5
    run_cmd("up5_clr", 1'b1, 4'd5, 1'b1, {1'b0, 1'b0, 4'h5}, 6, 5, 1);
    // zero length, no clear: response on the cycle after accept
    run_cmd("len0", 1'b1, 4'd0, 1'b0, {1'b0, 1'b0, 4'h5}, 0, 0, 0);
    // down 2, no clear: 5 -> 3
    run_cmd("dn2", 1'b0, 4'd2, 1'b0, {1'b0, 1'b0, 4'h3}, 2, 2, 0);

    // up 10 from 3, abort in the 4th RUN cycle: 4 steps -> 7
    exp_q.push_back({1'b1, 1'b0, 4'h7});
    send(1'b1, 4'd10, 1'b0);
    repeat (3) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    wait_rsp(lat);
    check("abort_lat", lat, 4);
    check("abort_ce", ce_total - ce0, 4);

    // Response back-pressure with a pending command
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 4'h8});
    send(1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    cmd_up    = 1'b1;
    cmd_len   = 4'd2;
    cmd_clr   = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, 4'h8);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_state", dbg_state, DONE);
    end
    exp_q.push_back({1'b0, 1'b0, 4'hA});
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_hs_state", dbg_state, IDLE);
    check("post_hs_cmd_ready", cmd_ready, 1);
    send(1'b1, 4'd2, 1'b0);
    wait_rsp(lat);
    check("queued_lat", lat, 2);

    // Reset in the 2nd RUN cycle of an 8-step run: no response
    send(1'b1, 4'd8, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_cnt_ce", cnt_ce, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_cnt_rst", cnt_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cnt_data", cnt_data, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_still_idle", dbg_state, IDLE);

    // Abort coincident with the last step: completion wins
    exp_q.push_back({1'b0, 1'b0, 4'h2});
    send(1'b1, 4'd2, 1'b0);
    @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    wait_rsp(lat);
    check("last_abort_ce", ce_total - ce0, 2);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
